// File: rtl/cosine_quadrature.sv
// cosine_quadrature: 3-stage full-wave quadrature cos/sin generator (magnitude + sign per coil), valid/ready flow control.
// Define COSINE_SCALE_EN to build the amplitude multiplier; otherwise amp is ignored and magnitudes pass at full scale.

module cosine_quadrature_lane #(
  parameter int PHASE_W = 8,
  parameter int AMP_W   = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               adv,
  input  logic [PHASE_W-1:0] p,
  input  logic [AMP_W-1:0]   amp_s2,
  output logic [AMP_W-1:0]   mag,
  output logic               neg
);
  localparam int RW = PHASE_W - 2;
  localparam int N  = 1 << RW;
  typedef logic [N-1:0][AMP_W-1:0] table_t;

  function automatic table_t gen_table();
    table_t t;
    real    v;
    for (int i = 0; i < N; i++) begin
      v    = real'((1 << AMP_W) - 1) * $cos(3.14159265358979323846 / 2.0 * real'(i) / real'(N));
      t[i] = AMP_W'($rtoi(v + 0.5));
    end
    return t;
  endfunction

  localparam table_t TABLE = gen_table();

  logic [1:0]    q;
  logic [RW-1:0] r;
  assign q = p[PHASE_W-1 -: 2];
  assign r = p[RW-1:0];

  // S1: fold onto the quarter wave
  logic          odd_s1, sign_s1, oz_s1;
  logic [RW-1:0] r_s1;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      odd_s1  <= 1'b0;
      sign_s1 <= 1'b0;
      oz_s1   <= 1'b0;
      r_s1    <= '0;
    end else if (adv) begin
      odd_s1  <= q[0];
      sign_s1 <= (q == 2'd1 && r != '0) || q == 2'd2;
      oz_s1   <= q[0] && r == '0;
      r_s1    <= r;
    end
  end

  // S2: table read; odd quadrants mirror to N-r, with r==0 forced to zero
  logic [RW-1:0]    idx;
  logic [AMP_W-1:0] mag_s2;
  logic             sign_s2;
  assign idx = odd_s1 ? (~r_s1 + RW'(1)) : r_s1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mag_s2  <= '0;
      sign_s2 <= 1'b0;
    end else if (adv) begin
      mag_s2  <= oz_s1 ? '0 : TABLE[idx];
      sign_s2 <= sign_s1;
    end
  end

  // S3: optional scale, then output register
  logic [AMP_W-1:0] scaled;
`ifdef COSINE_SCALE_EN
  logic [AMP_W:0]   amp_p1;
  logic [2*AMP_W:0] prod;
  assign amp_p1 = {1'b0, amp_s2} + (AMP_W+1)'(1);
  assign prod   = (2*AMP_W+1)'(mag_s2) * (2*AMP_W+1)'(amp_p1);
  assign scaled = prod[2*AMP_W-1:AMP_W];
`else
  logic amp_unused;
  assign amp_unused = ^amp_s2;
  assign scaled     = mag_s2;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mag <= '0;
      neg <= 1'b0;
    end else if (adv) begin
      mag <= scaled;
      neg <= sign_s2 && scaled != '0;
    end
  end
endmodule

module cosine_quadrature #(
  parameter int PHASE_W = 8,
  parameter int AMP_W   = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PHASE_W-1:0] phase,
  input  logic [AMP_W-1:0]   amp,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [AMP_W-1:0]   cos_mag,
  output logic               cos_neg,
  output logic [AMP_W-1:0]   sin_mag,
  output logic               sin_neg
);
  localparam int STAGES = 3;
  localparam int LANES  = 2;
  localparam int N      = 1 << (PHASE_W - 2);

  logic              adv;
  logic [STAGES:1]   vld_pipe;

  // Global stall: every stage moves only when the output slot frees up
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)  vld_pipe <= '0;
    else if (adv) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
  end

  logic [AMP_W-1:0] amp_s2;
`ifdef COSINE_SCALE_EN
  logic [AMP_W-1:0] amp_s1;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      amp_s1 <= '0;
      amp_s2 <= '0;
    end else if (adv) begin
      amp_s1 <= amp;
      amp_s2 <= amp_s1;
    end
  end
`else
  logic amp_unused;
  assign amp_unused = ^amp;
  assign amp_s2     = '1;
`endif

  // Lane 0 is cosine; lane 1 is sine, a quarter revolution behind
  logic [LANES-1:0][PHASE_W-1:0] lane_p;
  logic [LANES-1:0][AMP_W-1:0]   lane_mag;
  logic [LANES-1:0]              lane_neg;
  assign lane_p[0] = phase;
  assign lane_p[1] = phase - PHASE_W'(N);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    cosine_quadrature_lane #(.PHASE_W(PHASE_W), .AMP_W(AMP_W)) u_lane (
      .clk    (clk),
      .resetn (resetn),
      .adv    (adv),
      .p      (lane_p[g]),
      .amp_s2 (amp_s2),
      .mag    (lane_mag[g]),
      .neg    (lane_neg[g])
    );
  end

  assign cos_mag = lane_mag[0];
  assign cos_neg = lane_neg[0];
  assign sin_mag = lane_mag[1];
  assign sin_neg = lane_neg[1];
endmodule

// File: tb/tb_cosine_quadrature.sv
// Directed bench for cosine_quadrature: cardinal/fold vectors, full sweep vs real-math model,
// scaling, latency/throughput, backpressure and mid-stream reset.
`timescale 1ns/1ps
module tb_cosine_quadrature;
  localparam int  PW = 8;
  localparam int  AW = 8;
  localparam real PI = 3.14159265358979323846;
`ifdef COSINE_SCALE_EN
  localparam bit SCALE = 1'b1;
`else
  localparam bit SCALE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [PW-1:0] phase = '0;
  logic [AW-1:0] amp = '0;
  logic          in_ready, out_valid, cos_neg, sin_neg;
  logic [AW-1:0] cos_mag, sin_mag;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct { int cm; int cn; int sm; int sn; int cyc; } res_t;
  res_t rq[$];
  int   acc_q[$];
  res_t mon_r;

  cosine_quadrature #(.PHASE_W(PW), .AMP_W(AW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .phase     (phase),
    .amp       (amp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cos_mag   (cos_mag),
    .cos_neg   (cos_neg),
    .sin_mag   (sin_mag),
    .sin_neg   (sin_neg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes are recorded mid-cycle, tagged with the cycle they are offered in
  always @(negedge clk) begin
    if (resetn) begin
      if (in_valid && in_ready) acc_q.push_back(cyc);
      if (out_valid && out_ready) begin
        mon_r.cm = int'(cos_mag); mon_r.cn = int'(cos_neg);
        mon_r.sm = int'(sin_mag); mon_r.sn = int'(sin_neg);
        mon_r.cyc = cyc;
        rq.push_back(mon_r);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic res_t model(input int p, input int a);
    res_t m;
    real  c, s;
    c = 255.0 * $cos(2.0 * PI * real'(p) / 256.0);
    s = 255.0 * $sin(2.0 * PI * real'(p) / 256.0);
    m.cm = $rtoi((c < 0.0 ? -c : c) + 0.5);
    m.sm = $rtoi((s < 0.0 ? -s : s) + 0.5);
    if (SCALE) begin
      m.cm = (m.cm * (a + 1)) >> 8;
      m.sm = (m.sm * (a + 1)) >> 8;
    end
    m.cn  = (c < 0.0 && m.cm != 0) ? 1 : 0;
    m.sn  = (s < 0.0 && m.sm != 0) ? 1 : 0;
    m.cyc = 0;
    return m;
  endfunction

  task automatic push(input int p, input int a);
    int t = 0;
    in_valid = 1'b1; phase = PW'(p); amp = AW'(a);
    while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (t >= 50) begin
      n_cmp++; n_err++;
      $display("FAIL push_timeout: in_ready=0 for %0d cycles, required 1", t);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pop(output res_t r, output bit ok);
    int t = 0;
    while (rq.size() == 0 && t < 50) begin @(posedge clk); #1; t++; end
    ok = rq.size() != 0;
    if (ok) r = rq.pop_front();
    else    r = '{-1, -1, -1, -1, -1};
  endtask

  task automatic drain();
    out_ready = 1'b1; in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rq.delete(); acc_q.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || cos_mag !== '0 || sin_mag !== '0 || cos_neg !== 1'b0 || sin_neg !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b c=%0d/%b s=%0d/%b, required all 0", out_valid, cos_mag, cos_neg, sin_mag, sin_neg);
    end
    resetn = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_idle_valid: got %b, required 0", out_valid); end
  endtask

  task automatic test_cardinal();
    int   vp[7] = '{0, 64, 128, 192, 96, 255, 32};
    int   ve[7][4] = '{'{255,0,0,0}, '{0,0,255,0}, '{255,1,0,0}, '{0,0,255,1},
                       '{180,1,180,0}, '{255,0,6,1}, '{180,0,180,0}};
    res_t r;
    bit   ok;
    drain();
    for (int i = 0; i < 7; i++) push(vp[i], 255);
    for (int i = 0; i < 7; i++) begin
      pop(r, ok);
      n_cmp++;
      if (!ok || r.cm !== ve[i][0] || r.cn !== ve[i][1] || r.sm !== ve[i][2] || r.sn !== ve[i][3]) begin
        n_err++;
        $display("FAIL cardinal p=%0d: got cos %0d/%0d sin %0d/%0d, required cos %0d/%0d sin %0d/%0d",
                 vp[i], r.cm, r.cn, r.sm, r.sn, ve[i][0], ve[i][1], ve[i][2], ve[i][3]);
      end
    end
  endtask

  task automatic test_sweep(input int a);
    res_t r, e;
    bit   ok;
    drain();
    for (int p = 0; p < 256; p++) push(p, a);
    for (int p = 0; p < 256; p++) begin
      pop(r, ok);
      e = model(p, a);
      n_cmp++;
      if (!ok || r.cm !== e.cm || r.cn !== e.cn || r.sm !== e.sm || r.sn !== e.sn) begin
        n_err++;
        $display("FAIL sweep amp=%0d p=%0d: got cos %0d/%0d sin %0d/%0d, required cos %0d/%0d sin %0d/%0d",
                 a, p, r.cm, r.cn, r.sm, r.sn, e.cm, e.cn, e.sm, e.sn);
      end
    end
  endtask

  task automatic test_scale();
    int   vp[5] = '{0, 96, 128, 192, 255};
    int   va[5] = '{127, 0, 0, 63, 0};
`ifdef COSINE_SCALE_EN
    int   ve[5][4] = '{'{(255*128)>>8,0,0,0}, '{0,0,0,0}, '{0,0,0,0}, '{0,0,63,1}, '{0,0,0,0}};
`else
    int   ve[5][4] = '{'{255,0,0,0}, '{180,1,180,0}, '{255,1,0,0}, '{0,0,255,1}, '{255,0,6,1}};
`endif
    res_t r;
    bit   ok;
    drain();
    for (int i = 0; i < 5; i++) push(vp[i], va[i]);
    for (int i = 0; i < 5; i++) begin
      pop(r, ok);
      n_cmp++;
      if (!ok || r.cm !== ve[i][0] || r.cn !== ve[i][1] || r.sm !== ve[i][2] || r.sn !== ve[i][3]) begin
        n_err++;
        $display("FAIL scale p=%0d amp=%0d: got cos %0d/%0d sin %0d/%0d, required cos %0d/%0d sin %0d/%0d",
                 vp[i], va[i], r.cm, r.cn, r.sm, r.sn, ve[i][0], ve[i][1], ve[i][2], ve[i][3]);
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t r, e;
    bit   ok;
    int   first;
    drain();
    for (int i = 0; i < 8; i++) push(i * 8, 255);
    n_cmp++;
    if (acc_q.size() != 8) begin n_err++; $display("FAIL b2b_accepts: got %0d, required 8", acc_q.size()); end
    first = (acc_q.size() > 0) ? acc_q[0] : -100;
    for (int i = 0; i < 8; i++) begin
      pop(r, ok);
      e = model(i * 8, 255);
      n_cmp++;
      if (!ok || r.cyc !== first + 3 + i || r.cm !== e.cm || r.cn !== e.cn || r.sm !== e.sm || r.sn !== e.sn) begin
        n_err++;
        $display("FAIL b2b[%0d]: got cycle %0d cos %0d/%0d sin %0d/%0d, required cycle %0d cos %0d/%0d sin %0d/%0d",
                 i, r.cyc, r.cm, r.cn, r.sm, r.sn, first + 3 + i, e.cm, e.cn, e.sm, e.sn);
      end
    end
  endtask

  task automatic test_backpressure();
    int   ph[4] = '{32, 96, 160, 224};
    res_t r, e, e0;
    bit   ok;
    drain();
    out_ready = 1'b0;
    amp = 8'd255;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; phase = PW'(ph[i]);
      @(posedge clk); #1;
    end
    phase = PW'(ph[3]);
    e0 = model(ph[0], 255);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || cos_mag !== AW'(e0.cm) || sin_mag !== AW'(e0.sm)
          || cos_neg !== e0.cn[0] || sin_neg !== e0.sn[0]) begin
        n_err++;
        $display("FAIL stall[%0d]: got v=%b rdy=%b cos %0d/%b sin %0d/%b, required v=1 rdy=0 cos %0d/%0d sin %0d/%0d",
                 k, out_valid, in_ready, cos_mag, cos_neg, sin_mag, sin_neg, e0.cm, e0.cn, e0.sm, e0.sn);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pop(r, ok);
      e = model(ph[i], 255);
      n_cmp++;
      if (!ok || r.cm !== e.cm || r.cn !== e.cn || r.sm !== e.sm || r.sn !== e.sn) begin
        n_err++;
        $display("FAIL bp_order[%0d]: got cos %0d/%0d sin %0d/%0d, required cos %0d/%0d sin %0d/%0d",
                 i, r.cm, r.cn, r.sm, r.sn, e.cm, e.cn, e.sm, e.sn);
      end
    end
    repeat (6) @(posedge clk);
    #1;
    n_cmp++;
    if (rq.size() != 0) begin n_err++; $display("FAIL bp_dup: got %0d extra results, required 0", rq.size()); end
  endtask

  task automatic test_reset_midstream();
    res_t r, e;
    bit   ok;
    drain();
    push(16, 255); push(48, 255); push(80, 255);
    #1 resetn = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || cos_mag !== '0 || sin_mag !== '0 || cos_neg !== 1'b0 || sin_neg !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_outputs: got v=%b c=%0d/%b s=%0d/%b, required all 0", out_valid, cos_mag, cos_neg, sin_mag, sin_neg);
    end
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL midreset_ready: got %b, required 1", in_ready); end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (rq.size() != 0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_flush: got %0d results v=%b, required 0 results v=0", rq.size(), out_valid);
    end
    acc_q.delete();
    push(160, 255);
    pop(r, ok);
    e = model(160, 255);
    n_cmp++;
    if (!ok || acc_q.size() != 1 || r.cyc !== acc_q[0] + 3 || r.cm !== e.cm || r.cn !== e.cn || r.sm !== e.sm || r.sn !== e.sn) begin
      n_err++;
      $display("FAIL midreset_first: got cycle %0d cos %0d/%0d sin %0d/%0d, required accept+3 cos %0d/%0d sin %0d/%0d",
               r.cyc, r.cm, r.cn, r.sm, r.sn, e.cm, e.cn, e.sm, e.sn);
    end
  endtask

  initial begin
    test_reset();
    test_cardinal();
    test_sweep(255);
    test_scale();
    test_sweep(0);
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
